// File: rtl/coin_acceptor.sv
// coin_acceptor
// Front end of the vending machine. It debounces the raw coin-slot sensor,
// decodes the denomination, accumulates credit and tells the controller
// (via a one-cycle `coin` pulse) when a full price has been paid. The
// controller's `vend_done` acknowledge deducts the price. `cancel` refunds
// whatever credit remains.
//
// Optional feature: define COIN_TIMEOUT_EN to add an idle timer. When the
// timer expires it refunds unclaimed credit, exactly as if cancel had been
// pressed. Without the macro, credit is held indefinitely.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   synchronous, active-high
//   coin_sense     in   raw coin-slot sensor level (may bounce)
//   coin_value     in   denomination: 00=1, 01=2, 10=5, 11=invalid
//   cancel         in   user cancel request (level)
//   vend_done      in   one-cycle acknowledge from the controller
//   coin           out  one-cycle pulse: credit has reached PRICE
//   credit         out  current credit (registered)
//   refund         out  one-cycle pulse: pay out refund_amount
//   refund_amount  out  refund value while refund=1, otherwise 0
//   reject         out  one-cycle pulse: invalid code or credit overflow
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PRICE           = 3,
  parameter int MAX_CREDIT      = 15,
  parameter int CREDIT_W        = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_sense,
  input  logic [1:0]          coin_value,
  input  logic                cancel,
  input  logic                vend_done,
  output logic                coin,
  output logic [CREDIT_W-1:0] credit,
  output logic                refund,
  output logic [CREDIT_W-1:0] refund_amount,
  output logic                reject
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  // The extra bits hold credit + 5 without wrapping, for the overflow test.
  localparam int SUM_W = CREDIT_W + 3;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_RELEASE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          code_q, code_d;
  logic                armed_q, armed_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                coin_q, coin_d;
  logic                refund_q, refund_d;
  logic [CREDIT_W-1:0] amount_q, amount_d;
  logic                reject_q, reject_d;

  logic                accept;
  logic                timeout_fire;
  logic [CREDIT_W-1:0] credit_v;
  logic                armed_v;
  logic [SUM_W-1:0]    sum;

  function automatic logic [SUM_W-1:0] coin_units(input logic [1:0] code);
    case (code)
      2'b00:   coin_units = SUM_W'(1);
      2'b01:   coin_units = SUM_W'(2);
      2'b10:   coin_units = SUM_W'(5);
      default: coin_units = '0;
    endcase
  endfunction

  function automatic logic fits_ceiling(input logic [SUM_W-1:0] total);
    fits_ceiling = (total <= SUM_W'(MAX_CREDIT));
  endfunction

  // Debounce FSM and credit datapath, next-state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    accept   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (coin_sense) begin
          state_d = S_DEBOUNCE;
          cnt_d   = CNT_W'(1);
          code_d  = coin_value;
        end
      end
      S_DEBOUNCE: begin
        if (!coin_sense) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (int'(cnt_q) + 1 >= DEBOUNCE_CYCLES) begin
          // This sample completes the high run, so the coin is accepted now.
          accept  = 1'b1;
          state_d = S_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        // A coin held in the slot is counted only once.
        if (!coin_sense) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Same-cycle priority: the vend deduction comes first, then the coin is
    // added, and then cancel refunds whatever credit results.
    credit_v = credit_q;
    armed_v  = armed_q;
    if (vend_done && armed_q) begin
      credit_v = credit_v - CREDIT_W'(PRICE);
      armed_v  = 1'b0;
    end

    reject_d = 1'b0;
    sum      = {3'b000, credit_v} + coin_units(code_q);
    if (accept) begin
      if (code_q == 2'b11 || !fits_ceiling(sum)) begin
        reject_d = 1'b1;
      end else begin
        credit_v = sum[CREDIT_W-1:0];
      end
    end

    refund_d = 1'b0;
    amount_d = '0;
    if ((cancel || timeout_fire) && credit_v != '0) begin
      refund_d = 1'b1;
      amount_d = credit_v;
      credit_v = '0;
      armed_v  = 1'b0;
    end

    // The pulse is produced once per price reached. armed holds it off until
    // the controller acknowledges with vend_done.
    coin_d = 1'b0;
    if (!refund_d && !armed_v && credit_v >= CREDIT_W'(PRICE)) begin
      coin_d  = 1'b1;
      armed_v = 1'b1;
    end

    credit_d = credit_v;
    armed_d  = armed_v;
  end

`ifdef COIN_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] idle_q, idle_d;

  assign timeout_fire = (int'(idle_q) == TIMEOUT_CYCLES);

  // The timer runs only while credit is waiting to reach the price
  // (credit>0, armed=0). Any activity restarts it.
  always_comb begin
    idle_d = '0;
    if (!(accept || vend_done || cancel || timeout_fire) &&
        credit_q != '0 && !armed_q) begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`else
  // With the feature compiled out the timeout never fires. The parameter
  // stays referenced so the parameter list is identical in both builds.
  assign timeout_fire = (TIMEOUT_CYCLES < 0);
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      credit_q <= '0;
      coin_q   <= 1'b0;
      refund_q <= 1'b0;
      amount_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      credit_q <= credit_d;
      coin_q   <= coin_d;
      refund_q <= refund_d;
      amount_q <= amount_d;
      reject_q <= reject_d;
    end
    code_q <= code_d;
  end

  assign coin          = coin_q;
  assign credit        = credit_q;
  assign refund        = refund_q;
  assign refund_amount = amount_q;
  assign reject        = reject_q;

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Front-end stage directly upstream of the vending-machine controller FSM.
- Debounces the raw coin-slot sensor, decodes the coin denomination and accumulates credit.
- Raises the single-cycle `coin` pulse that tells the controller a full price has been paid.
- Consumes the controller's `received` acknowledge (wired to `vend_done`) to deduct the price, and services `cancel` with a refund of the remaining credit.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive high samples of coin_sense needed to accept a coin; min 1.
- PRICE, 3: drink price in credit units; 1..MAX_CREDIT.
- MAX_CREDIT, 15: credit ceiling; a coin that would exceed it is rejected.
- CREDIT_W, 4: width of credit and refund_amount; must hold MAX_CREDIT.
- TIMEOUT_CYCLES, 1000: idle cycles before auto-refund; used only with COIN_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- coin_sense  input  1  raw coin-slot sensor level, may bounce.
- coin_value  input  2  denomination code: 00=1, 01=2, 10=5, 11=invalid; sampled on the first high cycle of coin_sense.
- cancel  input  1  user cancel request, level, sampled each cycle.
- vend_done  input  1  one-cycle pulse from the controller when the drink has been received.
- coin  output  1  one-cycle pulse: credit has reached PRICE (to controller).
- credit  output  CREDIT_W  current credit, registered.
- refund  output  1  one-cycle pulse: pay out refund_amount.
- refund_amount  output  CREDIT_W  value to return; valid only while refund=1, otherwise 0.
- reject  output  1  one-cycle pulse: coin rejected (invalid code or overflow).

Behaviour:
- Reset: coin=0, credit=0, refund=0, refund_amount=0, reject=0. Debounce FSM goes to S_IDLE; counter=0; armed=0. Reset mid-debounce discards the coin; it is not credited.
- Debounce FSM:
  - S_IDLE: coin_sense=1 -> S_DEBOUNCE; cnt=1; latch coin_value.
  - S_DEBOUNCE: coin_sense=0 -> S_IDLE, glitch ignored, no outputs. Else cnt++. When cnt reaches DEBOUNCE_CYCLES the coin is accepted -> S_RELEASE.
  - S_RELEASE: wait for coin_sense=0 -> S_IDLE. Holding the sensor high never double-counts.
  - DEBOUNCE_CYCLES=1: accept occurs on the cycle after the first high sample.
- Accept event:
  - Latched code 11 -> reject=1 for one cycle; credit unchanged.
  - credit+value > MAX_CREDIT -> reject=1; credit unchanged. No saturation, no wrap.
  - Otherwise credit <= credit+value, visible the cycle after accept.
- coin pulse:
  - Registered; asserted in the same cycle the updated credit first shows >= PRICE while armed=0; armed is then set to 1.
  - Exactly one pulse per vend; further coins while armed add credit but give no pulse.
- vend_done with armed=1:
  - credit <= credit-PRICE; armed <= 0.
  - If the remaining credit is still >= PRICE, coin pulses again the following cycle.
  - vend_done with armed=0 is ignored.
- cancel:
  - credit>0 -> refund=1 and refund_amount=credit for one cycle; credit <= 0; armed <= 0.
  - cancel with credit=0 -> no refund pulse.
  - cancel held high refunds once; any coin accepted while it is held is refunded on the accept cycle.
- Same-cycle priority, applied in order:
  1. vend_done deduction first.
  2. Coin accept is added next.
  3. cancel then refunds the result, e.g. credit=5, vend_done+cancel -> refund_amount=2.
- No coin pulse is generated on a cycle where cancel refunds.

Optional Feature:
- Macro: COIN_TIMEOUT_EN.
- Defined:
  - An idle counter resets on any accept, vend_done, or cancel, and counts while credit>0 and armed=0.
  - At TIMEOUT_CYCLES it acts as an internal cancel: refund pulse, credit cleared.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Not defined: no counter; credit is held indefinitely.

Test Plan:
- Bounce: coin_sense 1,0,1,1,0 with DEBOUNCE_CYCLES=4 -> no credit change, reject=0; then 6 cycles high with code 01 -> credit=2, no coin pulse.
- Reach price: credit=2, accept code 00 -> credit=3 with coin=1 for exactly one cycle; add code 10 -> credit=8, no second pulse.
- Vend: credit=8, vend_done -> credit=5, coin pulses next cycle; vend_done -> credit=2, no pulse.
- Overflow/invalid: credit=12, accept code 10 -> reject=1, credit stays 12; code 11 at credit=0 -> reject=1, credit 0.
- Cancel: credit=5, cancel and vend_done same cycle -> refund=1, refund_amount=2, credit=0; cancel at credit=0 -> no refund.
- Timeout (COIN_TIMEOUT_EN, TIMEOUT_CYCLES=10): credit=2 idle 10 cycles -> refund=1, refund_amount=2, credit=0; reset asserted mid-debounce -> all outputs 0, coin not credited.
